axi4_vga_pattern_src: RTL and testbench
=======================================

# axi4_vga_pattern_src

AXI4-Stream master that generates 12-bit RGB pixels for the VGA sink (`axi4_vga_v1_0`): one beat per pixel in raster order, `last` on the final pixel of every line. It drives the sink's `data`/`valid`/`last` inputs and honours its `ready`. It supplies bring-up and test patterns without a framebuffer or DMA. Frames are atomic: once started, a frame is always streamed to completion.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line; must be a multiple of 8.
- `V_ACTIVE`, 480: lines per frame.
- `CNT_W`, 10: width of the x and y counters; must satisfy 2^CNT_W ≥ max(H_ACTIVE, V_ACTIVE).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: request streaming; sampled only at frame boundaries.
- `mode` in 2: pattern select; 0 solid, 1 colour bars, 2 gradient, 3 checkerboard.
- `color` in 12: solid colour {R[11:8], G[7:4], B[3:0]}.
- `ready` in 1: AXI4-Stream TREADY from the sink.
- `data` out 12: TDATA, the pixel {R,G,B}.
- `valid` out 1: TVALID.
- `last` out 1: TLAST; high on pixel x = H_ACTIVE-1 of every line.
- `frame_done` out 1: one-cycle pulse when the final pixel of a frame is accepted.

## Operation
- State IDLE: `valid`=0 and x=y=0.
  - A rising edge with `enable`=1 moves to STREAM.
  - The same edge latches `mode` and `color` into frame registers and registers `valid`=1 with pixel (0,0).
- State STREAM: a beat is accepted on any edge where `valid`&&`ready`.
  - On acceptance, the next pixel is registered.
  - With no acceptance, `data`, `last` and `valid` hold exactly (AXI stability rule).
- Advance: x increments. At x=H_ACTIVE-1, x wraps to 0 and y increments.
- At (H_ACTIVE-1, V_ACTIVE-1), acceptance pulses `frame_done` for one cycle and sets x=y=0, then:
  - `enable`=1: stay in STREAM, re-latch `mode`/`color`, and present pixel (0,0) on the same edge. There is no bubble.
  - `enable`=0: go to IDLE with `valid`=0.
- Deasserting `enable` mid-frame has no effect until the frame ends. Changes to `mode`/`color` mid-frame are ignored.
- Patterns, computed from the latched mode:
  - Solid: the latched `color`.
  - Bars: 8 bars, each H_ACTIVE/8 pixels wide. In order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
    - The bar index comes from a 3-bit bar counter plus a bar-width counter.
    - Both counters reset at x wrap. No divider is used.
  - Gradient: R=x[7:4], G=y[7:4], B=x[7:4]^y[7:4].
  - Checkerboard: FFF when x[5]^y[5]=1, else 000.
- `last` = (x == H_ACTIVE-1) and is registered alongside `data`.
- Reset mid-frame is asynchronous. All state clears immediately. After reset releases, the next frame starts at (0,0).

## Timing
- Reset values: `valid`=0, `last`=0, `data`=12'h000, `frame_done`=0, state IDLE, all counters 0.
- Latency: `valid` is high one edge after `enable` is first sampled high in IDLE; outputs are registered.
- Throughput: 1 pixel per cycle while `ready`=1, continuous across line and frame boundaries.
- `ready` low stalls for any number of cycles with outputs frozen.
- `frame_done` is asserted in the cycle after the final beat's acceptance edge.
- No combinational path from `ready` to `valid`; `data` and `last` are driven only from registers.

## Structure
- Package `vga_pkg` holds:
  - the pixel width constant (12);
  - the mode localparams MODE_SOLID, MODE_BARS, MODE_GRAD and MODE_CHECK;
  - the state encoding IDLE/STREAM;
  - the 8-entry bar colour constants.
- One sub-module, `vga_raster_counter`, holds the x/y/bar counters.
  - Inputs: `advance`, `clear`.
  - Outputs: x, y, bar index, end_of_line, end_of_frame.
- The top level contains the FSM, pattern mux and output registers.

## Test plan
Test plan uses H_ACTIVE=16, V_ACTIVE=4 unless noted.
- Reset, then `enable`=1, `mode`=0, `color`=12'hF00, `ready`=1 → `valid` rises the next edge.
  - 64 beats, all 12'hF00.
  - `last` on beats 16, 32, 48 and 64.
  - One `frame_done` pulse.
- `mode`=1 with `ready` held 1 → per line, two beats each of FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- `mode`=3, H=V=64 → data 000 for x<32,y<32 and FFF for x=32,y=0. Checks the x[5]^y[5] polarity.
- `mode`=2, H=V=64, `ready` held 1, one frame → beat (x=16,y=32) = 12'h123.
- Random `ready` toggling with `mode`=2 → while `valid`&&!`ready`, `data`/`last` are stable.
  - The accepted sequence equals the `ready`=1 reference, with no duplicate or lost pixels.
- Boundary cases:
  - `enable` held 1 → frame 2's pixel (0,0) follows frame 1's last pixel with no gap.
  - `enable` dropped mid-frame → the frame completes, then `valid`=0.
  - `reset` asserted mid-line → `valid`=0 immediately. After re-enable, the stream restarts at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern source: pixel width, pattern modes,
// FSM encoding and the colour-bar palette.
package vga_pkg;

  localparam int PIX_W = 12;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SOLID = 2'd0;
  localparam mode_t MODE_BARS  = 2'd1;
  localparam mode_t MODE_GRAD  = 2'd2;
  localparam mode_t MODE_CHECK = 2'd3;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  // Classic SMPTE-style order, left to right across the line.
  localparam logic [PIX_W-1:0] BAR_COLORS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Raster position generator: x/y coordinates plus a divider-free bar index
// built from a bar-width counter that wraps every H_ACTIVE/8 pixels.
module vga_raster_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             clear,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [2:0]       bar_idx,
  output logic             end_of_line,
  output logic             end_of_frame
);

  localparam int               BAR_W  = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BW_MAX = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] bw_q, bw_d;
  logic [2:0]       bar_q, bar_d;

  assign end_of_line  = (x_q == X_MAX);
  assign end_of_frame = end_of_line && (y_q == Y_MAX);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    bw_d  = bw_q;
    bar_d = bar_q;
    if (clear) begin
      x_d   = '0;
      y_d   = '0;
      bw_d  = '0;
      bar_d = '0;
    end else if (advance) begin
      if (end_of_line) begin
        x_d   = '0;
        bw_d  = '0;
        bar_d = '0;
        y_d   = end_of_frame ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        // Bar index steps each time the width counter completes one bar.
        if (bw_q == BW_MAX) begin
          bw_d  = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          bw_d = bw_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      bw_q  <= '0;
      bar_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      bw_q  <= bw_d;
      bar_q <= bar_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign bar_idx = bar_q;

endmodule

// File: rtl/axi4_vga_pattern_src.sv
// AXI4-Stream test-pattern master for the VGA sink: one beat per pixel in
// raster order, TLAST at end of line, frames always streamed to completion.
module axi4_vga_pattern_src
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [11:0]      color,
  input  logic             ready,
  output logic [PIX_W-1:0] data,
  output logic             valid,
  output logic             last,
  output logic             frame_done
);

  logic [0:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic             last_q;
  logic             eof_q;
  logic             fd_q, fd_d;
  logic [PIX_W-1:0] data_q;
  mode_t            mode_q;
  logic [11:0]      color_q;

  logic             load;
  logic             relatch;
  logic             stop;
  logic             accept;

  logic [CNT_W-1:0] x_w, y_w;
  logic [2:0]       bar_w;
  logic             eol_w, eof_w;

  mode_t            mode_sel;
  logic [11:0]      color_sel;
  logic [15:0]      x_ext, y_ext;
  logic [PIX_W-1:0] pix;
  logic             unused_ok;

  // The counters always point at the next pixel to be loaded into the output
  // registers, so a load and an advance happen on the same edge.
  vga_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_raster (
    .clk          (clk),
    .rst_n        (reset),
    .advance      (load),
    .clear        (stop),
    .x            (x_w),
    .y            (y_w),
    .bar_idx      (bar_w),
    .end_of_line  (eol_w),
    .end_of_frame (eof_w)
  );

  assign accept = valid_q && ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    fd_d    = 1'b0;
    load    = 1'b0;
    relatch = 1'b0;
    stop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = STREAM;
          valid_d = 1'b1;
          load    = 1'b1;
          relatch = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (eof_q) begin
            fd_d = 1'b1;
            if (enable) begin
              load    = 1'b1;
              relatch = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              stop    = 1'b1;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
    endcase
  end

  // A frame's first pixel must already use the freshly latched mode/colour.
  assign mode_sel  = relatch ? mode  : mode_q;
  assign color_sel = relatch ? color : color_q;
  assign x_ext     = 16'(x_w);
  assign y_ext     = 16'(y_w);
  assign unused_ok = ^{x_ext, y_ext};

  always_comb begin
    pix = '0;
    case (mode_sel)
      MODE_SOLID: pix = color_sel;
      MODE_BARS:  pix = bar_color(bar_w);
      MODE_GRAD:  pix = {x_ext[7:4], y_ext[7:4], x_ext[7:4] ^ y_ext[7:4]};
      default:    pix = (x_ext[5] ^ y_ext[5]) ? 12'hFFF : 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
      last_q  <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= '0;
      mode_q  <= MODE_SOLID;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
      if (relatch) begin
        mode_q  <= mode;
        color_q <= color;
      end
      if (load) begin
        data_q <= pix;
        last_q <= eol_w;
        eof_q  <= eof_w;
      end else if (stop) begin
        last_q <= 1'b0;
        eof_q  <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign last       = last_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_axi4_vga_pattern_src.sv
// Directed-plus-random bench: a 16x4 instance for stream/bars/stall/reset cases
// and a 64x64 instance for checkerboard polarity and gradient spot values.
module tb_axi4_vga_pattern_src;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_a = 1'b0, enable_b = 1'b0;
  logic        ready_a = 1'b0, ready_b = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] color = 12'h000;

  logic [11:0] data_a, data_b;
  logic        valid_a, valid_b, last_a, last_b, fd_a, fd_b;

  int checks = 0;
  int errors = 0;
  logic [11:0] got[$];

  always #5 clk = ~clk;

  axi4_vga_pattern_src #(.H_ACTIVE(16), .V_ACTIVE(4), .CNT_W(10)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .mode(mode), .color(color),
    .ready(ready_a), .data(data_a), .valid(valid_a), .last(last_a),
    .frame_done(fd_a)
  );

  axi4_vga_pattern_src #(.H_ACTIVE(64), .V_ACTIVE(64), .CNT_W(10)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .mode(mode), .color(color),
    .ready(ready_b), .data(data_b), .valid(valid_b), .last(last_b),
    .frame_done(fd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel straight from the pattern definitions.
  function automatic logic [11:0] ref_pix(input logic [1:0] m, input logic [11:0] c,
                                          input int x, input int y, input int h);
    int bar;
    case (m)
      2'd0: return c;
      2'd1: begin
        bar = x / (h / 8);
        case (bar)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      2'd2: return {4'((x / 16) % 16), 4'((y / 16) % 16), 4'(((x / 16) ^ (y / 16)) % 16)};
      default: return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Collect nbeats accepted beats starting at a negedge where valid should be up.
  task automatic run(input bit sel, input int nbeats, input logic [1:0] m,
                     input logic [11:0] c, input bit rnd, input int drop_at,
                     input bit scramble);
    int h, v, k, cyc, x, y;
    bit held, fd_exp, r;
    logic [11:0] hd, dd;
    logic hl, vv, ll, ff, en;
    h = sel ? 64 : 16;
    v = sel ? 64 : 4;
    k = 0; cyc = 0; held = 0; fd_exp = 0; hd = '0; hl = 1'b0;
    got.delete();
    while (k < nbeats && cyc < 20000) begin
      vv = sel ? valid_b : valid_a;
      dd = sel ? data_b : data_a;
      ll = sel ? last_b : last_a;
      ff = sel ? fd_b : fd_a;
      check("frame_done", 32'(ff), 32'(fd_exp));
      check("valid", 32'(vv), 32'd1);
      if (held) begin
        check("hold_data", 32'(dd), 32'(hd));
        check("hold_last", 32'(ll), 32'(hl));
      end
      fd_exp = 0;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) ready_b = r; else ready_a = r;
      held = !r; hd = dd; hl = ll;
      if (r) begin
        x = k % h;
        y = (k / h) % v;
        check("data", 32'(dd), 32'(ref_pix(m, c, x, y, h)));
        check("last", 32'(ll), 32'(x == h - 1));
        got.push_back(dd);
        if (x == h - 1 && y == v - 1) fd_exp = 1;
        k++;
        if (k == drop_at) begin
          if (sel) enable_b = 1'b0; else enable_a = 1'b0;
        end
        if (scramble && k == 5) begin
          mode  = m ^ 2'd2;
          color = ~c;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("beat_count", 32'(k), 32'(nbeats));
    ff = sel ? fd_b : fd_a;
    vv = sel ? valid_b : valid_a;
    en = sel ? enable_b : enable_a;
    check("frame_done_end", 32'(ff), 32'(fd_exp));
    check("valid_end", 32'(vv), 32'(en));
  endtask

  initial begin
    logic [11:0] c;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_last", 32'(last_a), 32'd0);
    check("rst_data", 32'(data_a), 32'h000);
    check("rst_frame_done", 32'(fd_a), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_valid", 32'(valid_a), 32'd0);
    $display("step: reset checked");

    // Solid colour, enable dropped mid-frame, mode/colour scrambled mid-frame.
    mode = 2'd0; color = 12'hF00; enable_a = 1'b1; ready_a = 1'b1;
    @(posedge clk); #1;
    check("latency_valid", 32'(valid_a), 32'd1);
    check("first_data", 32'(data_a), 32'hF00);
    @(negedge clk);
    run(0, 64, 2'd0, 12'hF00, 0, 10, 1);
    @(negedge clk);
    check("fd_one_cycle", 32'(fd_a), 32'd0);
    check("idle_after_frame", 32'(valid_a), 32'd0);
    $display("step: solid frame, %0d beats", got.size());

    // Colour bars, two back-to-back frames with enable held across the boundary.
    mode = 2'd1; color = 12'(($urandom));
    enable_a = 1'b1;
    @(negedge clk);
    run(0, 128, 2'd1, color, 0, 70, 0);
    @(negedge clk);
    $display("step: bars, %0d beats", got.size());

    // Gradient with random backpressure.
    mode = 2'd2; enable_a = 1'b1;
    @(negedge clk);
    run(0, 64, 2'd2, 12'h000, 1, 30, 0);
    @(negedge clk);
    $display("step: gradient random ready, %0d beats", got.size());

    // Solid random colour with random backpressure.
    c = 12'($urandom);
    mode = 2'd0; color = c; enable_a = 1'b1;
    @(negedge clk);
    run(0, 64, 2'd0, c, 1, 40, 0);
    @(negedge clk);
    $display("step: solid %0h random ready, %0d beats", c, got.size());

    // Checkerboard polarity on 64x64.
    mode = 2'd3; enable_b = 1'b1;
    @(negedge clk);
    run(1, 4096, 2'd3, 12'h000, 0, 100, 0);
    check("chk_x31_y0", 32'(got[31]), 32'h000);
    check("chk_x32_y0", 32'(got[32]), 32'hFFF);
    check("chk_x0_y32", 32'(got[32 * 64]), 32'hFFF);
    check("chk_x33_y33", 32'(got[33 * 64 + 33]), 32'h000);
    @(negedge clk);
    $display("step: checkerboard 64x64, %0d beats", got.size());

    // Gradient spot value on 64x64.
    mode = 2'd2; enable_b = 1'b1;
    @(negedge clk);
    run(1, 4096, 2'd2, 12'h000, 0, 100, 0);
    check("grad_x16_y32", 32'(got[32 * 64 + 16]), 32'h123);
    @(negedge clk);
    $display("step: gradient 64x64, %0d beats", got.size());

    // Asynchronous reset mid-line, then restart from (0,0).
    mode = 2'd3; enable_a = 1'b1;
    @(negedge clk);
    run(0, 20, 2'd3, 12'h000, 0, -1, 0);
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_a), 32'd0);
    check("async_rst_last", 32'(last_a), 32'd0);
    check("async_rst_data", 32'(data_a), 32'h000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(0, 64, 2'd3, 12'h000, 0, 10, 0);
    $display("step: reset mid-line and restart, %0d beats", got.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
